// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter and its result buffer.
package wb_pkg;

    localparam int FIFO_DEPTH_DEF   = 2;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_result_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LONG
    } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result buffer. Power-of-two depth so the pointers wrap naturally.
// Also exports a bitmask of destination registers currently held, for hazard lookup.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_result_t               push_data,
    input  logic                     pop,
    output wb_result_t               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              occ_mask
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_result_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   off;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Mark destinations of occupied slots; slot i is live when its distance from rd_ptr is below count.
    always_comb begin
        occ_mask = '0;
        off      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if ({1'b0, off} < count) begin
                occ_mask[mem[i].rd] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port register-file writeback arbiter: ALU results take priority,
// long-latency results queue in a small FIFO and are guaranteed a slot by a
// one-cycle ALU stall after the queue has been starved too long.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        long_valid,
    input  logic [4:0]  long_rd,
    input  logic [31:0] long_data,
    output logic        long_ready,
    input  logic        issue_valid,
    input  logic        issue_long,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_pending,
    output logic        rs2_pending,
    output logic        w_enabled,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        alu_stall
);

    localparam int              SW          = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_LAST = SW'(STARVE_LIMIT - 1);

    wb_result_t                     fifo_head;
    wb_result_t                     fifo_in;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    logic [31:0]                    fifo_occ;
    logic                           push;
    logic                           pop;
    logic                           alu_win;
    logic                           starve_inc;
    wb_src_t                        src;
    logic [SW-1:0]                  starve_cnt;
    logic                           w_from_long;
    logic [31:0]                    pending;
    logic [31:0]                    pend_nxt;

    assign fifo_in    = '{rd: long_rd, data: long_data};
    assign long_ready = !rst && !fifo_full;
    assign push       = long_valid && long_ready;

    // Per-cycle source selection; a stall cycle hands the slot to the FIFO head.
    always_comb begin
        alu_win    = alu_valid && !alu_stall;
        pop        = !alu_win && !fifo_empty;
        starve_inc = alu_win && !fifo_empty;
        if (alu_win)          src = SRC_ALU;
        else if (!fifo_empty) src = SRC_LONG;
        else                  src = SRC_NONE;
    end

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_in),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .occ_mask  (fifo_occ)
    );

    // Registered write port; writes to r0 are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_enabled   <= 1'b0;
            rd_addr     <= '0;
            rd_data     <= '0;
            w_from_long <= 1'b0;
        end else begin
            case (src)
                SRC_ALU: begin
                    w_enabled   <= (alu_rd != 5'd0);
                    rd_addr     <= alu_rd;
                    rd_data     <= alu_data;
                    w_from_long <= 1'b0;
                end
                SRC_LONG: begin
                    w_enabled   <= (fifo_head.rd != 5'd0);
                    rd_addr     <= fifo_head.rd;
                    rd_data     <= fifo_head.data;
                    w_from_long <= 1'b1;
                end
                default: begin
                    w_enabled   <= 1'b0;
                    w_from_long <= 1'b0;
                end
            endcase
        end
    end

    // Starvation tracking; the stall fires after the STARVE_LIMIT-th lost cycle and self-clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else begin
            if (fifo_count == '0 || pop) starve_cnt <= '0;
            else if (starve_inc)         starve_cnt <= starve_cnt + SW'(1);
            alu_stall <= starve_inc && (starve_cnt == STARVE_LAST);
        end
    end

    // Scoreboard next state: clear on a long writeback, then set so a same-cycle issue wins.
    always_comb begin
        pend_nxt = pending;
        if (w_enabled && w_from_long) pend_nxt[rd_addr] = 1'b0;
        if (issue_valid && issue_long && issue_rd != 5'd0) pend_nxt[issue_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pend_nxt;
    end

    assign rs1_pending = (rs1_addr != 5'd0) && (pending[rs1_addr] || fifo_occ[rs1_addr]);
    assign rs2_pending = (rs2_addr != 5'd0) && (pending[rs2_addr] || fifo_occ[rs2_addr]);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: inputs change 1ns after the rising edge,
// registered outputs are sampled there too, combinational ones after a further 1ns.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        long_valid;
    logic [4:0]  long_rd;
    logic [31:0] long_data;
    logic        long_ready;
    logic        issue_valid;
    logic        issue_long;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        w_enabled;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        alu_stall;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .long_valid  (long_valid),
        .long_rd     (long_rd),
        .long_data   (long_data),
        .long_ready  (long_ready),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_pending (rs1_pending),
        .rs2_pending (rs2_pending),
        .w_enabled   (w_enabled),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .alu_stall   (alu_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".w_en"}, 32'(w_enabled), 32'(en));
        if (en) begin
            chk({tag, ".rd"},   32'(rd_addr), 32'(rd));
            chk({tag, ".data"}, rd_data, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        long_valid = 0; long_rd = 0; long_data = 0;
        issue_valid = 0; issue_long = 0; issue_rd = 0;
        rs1_addr = 0; rs2_addr = 0;

        // reset state
        step(); step();
        chk("rst.w_en",    32'(w_enabled), 32'd0);
        chk("rst.rd",      32'(rd_addr),   32'd0);
        chk("rst.data",    rd_data,        32'd0);
        chk("rst.stall",   32'(alu_stall), 32'd0);
        chk("rst.lready",  32'(long_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.lready", 32'(long_ready), 32'd1);

        // ALU result appears one cycle later
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        step();
        chk_wr("alu1", 1'b1, 5'd5, 32'h11);
        alu_valid = 0;
        step();
        chk_wr("alu1_idle", 1'b0, 5'd0, 32'h0);

        // long result two cycles after handshake, pending[7] cleared by the write
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        rs1_addr = 7;
        #1;
        chk("long.pend_set", 32'(rs1_pending), 32'd1);
        long_valid = 1; long_rd = 7; long_data = 32'hAB;
        #1;
        chk("long.ready", 32'(long_ready), 32'd1);
        step();
        long_valid = 0;
        chk_wr("long.c1", 1'b0, 5'd0, 32'h0);
        chk("long.pend_q", 32'(rs1_pending), 32'd1);
        step();
        chk_wr("long.c2", 1'b1, 5'd7, 32'hAB);
        step();
        chk("long.pend_clr", 32'(rs1_pending), 32'd0);
        chk_wr("long.c3", 1'b0, 5'd0, 32'h0);

        // starvation: ALU held, one long queued; stall after 4 lost cycles
        alu_valid = 1; alu_rd = 2; alu_data = 32'h22;
        long_valid = 1; long_rd = 9; long_data = 32'h99;
        step();
        long_valid = 0;
        chk_wr("stv.alu0", 1'b1, 5'd2, 32'h22);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("stv.nostall%0d", k), 32'(alu_stall), 32'd0);
        end
        step();
        chk("stv.stall", 32'(alu_stall), 32'd1);
        chk_wr("stv.alu4", 1'b1, 5'd2, 32'h22);
        step();
        chk("stv.stall_off", 32'(alu_stall), 32'd0);
        chk_wr("stv.long", 1'b1, 5'd9, 32'h99);
        step();
        chk_wr("stv.alu_back", 1'b1, 5'd2, 32'h22);

        // fill FIFO while ALU busy, third push refused, order preserved
        long_valid = 1; long_rd = 10; long_data = 32'hA0;
        step();
        long_rd = 11; long_data = 32'hB0;
        #1;
        chk("full.ready1", 32'(long_ready), 32'd1);
        step();
        long_rd = 12; long_data = 32'hC0;
        rs1_addr = 10;
        #1;
        chk("full.ready0", 32'(long_ready), 32'd0);
        chk("full.rs_fifo", 32'(rs1_pending), 32'd1);
        step();
        chk("full.count", 32'(dut.u_fifo.count), 32'd2);
        alu_valid = 0; long_valid = 0;
        step();
        chk_wr("full.pop1", 1'b1, 5'd10, 32'hA0);
        chk("full.ready_back", 32'(long_ready), 32'd1);
        step();
        chk_wr("full.pop2", 1'b1, 5'd11, 32'hB0);
        step();
        chk_wr("full.empty", 1'b0, 5'd0, 32'h0);

        // rd=0 consumed without a write
        long_valid = 1; long_rd = 0; long_data = 32'h55;
        step();
        long_valid = 0;
        step();
        chk_wr("r0.nowrite", 1'b0, 5'd0, 32'h0);
        chk("r0.popped", 32'(dut.u_fifo.count), 32'd0);
        rs1_addr = 0;
        #1;
        chk("r0.never_pend", 32'(rs1_pending), 32'd0);

        // set beats clear on the same register
        issue_valid = 1; issue_long = 1; issue_rd = 3;
        step();
        issue_valid = 0;
        long_valid = 1; long_rd = 3; long_data = 32'h33;
        step();
        long_valid = 0;
        step();
        chk_wr("setclr.write", 1'b1, 5'd3, 32'h33);
        issue_valid = 1; issue_long = 1; issue_rd = 3;
        step();
        issue_valid = 0;
        rs2_addr = 3;
        #1;
        chk("setclr.pend3", 32'(rs2_pending), 32'd1);

        // reset mid-operation with two queued results and pending bits
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        long_valid = 1; long_rd = 4; long_data = 32'h44;
        issue_valid = 1; issue_long = 1; issue_rd = 4;
        step();
        long_rd = 5; long_data = 32'h45; issue_rd = 5;
        step();
        long_valid = 0; issue_valid = 0;
        chk("prerst.count", 32'(dut.u_fifo.count), 32'd2);
        rst = 1;
        step();
        chk("midrst.count",   32'(dut.u_fifo.count), 32'd0);
        chk("midrst.pending", dut.pending, 32'd0);
        chk("midrst.w_en",    32'(w_enabled), 32'd0);
        chk("midrst.lready",  32'(long_ready), 32'd0);
        rst = 0; alu_valid = 0;
        rs1_addr = 4;
        step();
        chk("postrst.w_en", 32'(w_enabled), 32'd0);
        chk("postrst.rs4",  32'(rs1_pending), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
